// File: rtl/lattice_readout_streamer.sv
// Streams one lattice field out of a single-port RAM, in address order, over a valid/ready link.
// Reads are credit-limited so the small output FIFO can never overflow under backpressure.
module lattice_readout_streamer #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned NUM_CELLS     = 2500,
    parameter int unsigned ROW_WIDTH     = 50,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0]    ram_data_out,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_eol,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned COL_W = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  eol;
        logic                  last;
    } beat_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] issue_idx_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [COL_W-1:0]         col_q;
    logic                     rd_valid_q;
    logic                     rd_eol_q;
    logic                     rd_last_q;
    beat_t                    fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [CNT_W-1:0]         occ_q;

    logic                     push;
    logic                     pop;
    logic                     issue;
    logic                     last_idx;
    logic                     end_of_row;
    logic [SUM_W-1:0]         committed;

    assign m_valid    = (occ_q != '0);
    assign m_data     = fifo_q[rd_ptr_q].data;
    assign m_eol      = fifo_q[rd_ptr_q].eol;
    assign m_last     = fifo_q[rd_ptr_q].last;
    assign busy       = (state_q != S_IDLE);
    assign pop        = m_valid & m_ready;
    assign push       = rd_valid_q;
    assign last_idx   = (issue_idx_q == ADDRESS_WIDTH'(NUM_CELLS - 1));
    assign end_of_row = (col_q == COL_W'(ROW_WIDTH - 1));
    // Entries already owed to the FIFO after this cycle's pop; a read may only issue with room left.
    assign committed  = SUM_W'(occ_q) + SUM_W'(rd_valid_q) - SUM_W'(pop);

    // Next-state, read issue and done decode.
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        done     = 1'b0;
        ram_addr = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_READ;
            end
            S_READ: begin
                if (committed < SUM_W'(FIFO_DEPTH)) begin
                    issue    = 1'b1;
                    ram_addr = issue_idx_q;
                    if (last_idx) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && m_last) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, issue counters, read pipeline and output FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_idx_q <= '0;
            addr_q      <= '0;
            col_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_eol_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;

            if (state_q == S_IDLE && start) begin
                issue_idx_q <= '0;
                col_q       <= '0;
            end else if (issue) begin
                addr_q <= issue_idx_q;
                if (!last_idx) issue_idx_q <= issue_idx_q + ADDRESS_WIDTH'(1);
                col_q <= end_of_row ? '0 : col_q + COL_W'(1);
            end

            rd_valid_q <= issue;
            rd_eol_q   <= issue && end_of_row;
            rd_last_q  <= issue && last_idx;

            if (push) begin
                fifo_q[wr_ptr_q] <= '{data: ram_data_out, eol: rd_eol_q, last: rd_last_q};
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_lattice_readout_streamer.sv
// Directed bench for lattice_readout_streamer: RAM model holds data = address,
// a per-cycle monitor checks ordering, flags, hold-under-stall and read credit.
module tb_lattice_readout_streamer;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned NC = 2500;
    localparam int unsigned RW = 50;
    localparam int unsigned FD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_out;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_eol;
    logic          m_last;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int exp_idx = 0;
    int beats = 0;
    int dones = 0;
    int max_addr = -1;
    int first_valid = -1;
    int done_rel = -1;
    bit prev_stall = 1'b0;
    bit got;

    lattice_readout_streamer #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CELLS(NC), .ROW_WIDTH(RW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ram_addr(ram_addr), .ram_data_out(ram_data_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_eol(m_eol), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM preloaded with data = address.
    always @(posedge clk) ram_data_out <= DW'(ram_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_frame();
        start_cyc   = cyc;
        exp_idx     = 0;
        beats       = 0;
        dones       = 0;
        max_addr    = -1;
        first_valid = -1;
        done_rel    = -1;
        prev_stall  = 1'b0;
    endtask

    task automatic monitor();
        int acc;
        if (rst) begin
            clear_frame();
        end else begin
            if (start && !busy) clear_frame();
            chk("fifo_overflow", 32'(dut.push && !dut.pop && (dut.occ_q == FD)), 32'(0));
            if (m_valid) begin
                if (first_valid < 0) first_valid = cyc - start_cyc;
                chk("m_data", 32'(m_data), 32'(exp_idx));
                chk("m_eol", 32'(m_eol), 32'((exp_idx % RW) == RW - 1));
                chk("m_last", 32'(m_last), 32'(exp_idx == NC - 1));
            end else if (prev_stall) begin
                chk("valid_held", 32'(m_valid), 32'(1));
            end
            chk("done", 32'(done), 32'(m_valid && m_ready && exp_idx == NC - 1));
            if (done) begin
                dones++;
                done_rel = cyc - start_cyc;
            end
            if (busy) begin
                if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
                acc = beats + int'(m_valid && m_ready);
                chk("outstanding", 32'((max_addr + 1 - acc) <= FD), 32'(1));
            end
            if (m_valid && m_ready) begin
                beats++;
                exp_idx = (exp_idx == NC - 1) ? 0 : exp_idx + 1;
            end
            prev_stall = m_valid && !m_ready;
        end
    endtask

    // Drive inputs just after the rising edge, sample outputs on the falling edge.
    task automatic step_cycle(input logic st, input logic rdy);
        @(posedge clk);
        #1;
        start   = st;
        m_ready = rdy;
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_done(input string tag, input int mode, input int extra, input int budget);
        int rel;
        logic rdy;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            rel = cyc + 1 - start_cyc;
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            step_cycle(rel == extra, rdy);
            if (dones > 0) got = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'(1));
    endtask

    task automatic check_frame(input string tag, input bit exact_timing);
        chk({tag, "_beats"}, 32'(beats), 32'(NC));
        chk({tag, "_dones"}, 32'(dones), 32'(1));
        chk({tag, "_first_valid_cycle"}, 32'(first_valid), 32'(3));
        if (exact_timing) chk({tag, "_done_cycle"}, 32'(done_rel), 32'(2502));
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        m_ready = 1'b0;
        repeat (3) step_cycle(1'b0, 1'b0);
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_ram_addr", 32'(ram_addr), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
        chk("rst_m_eol", 32'(m_eol), 32'(0));
        chk("rst_m_last", 32'(m_last), 32'(0));
        rst = 1'b0;
        repeat (2) step_cycle(1'b0, 1'b0);
        chk("idle_busy", 32'(busy), 32'(0));

        // Full frame, no backpressure.
        step_cycle(1'b1, 1'b1);
        wait_done("nobp", 0, -1, 3000);
        check_frame("nobp", 1'b1);
        step_cycle(1'b0, 1'b1);
        chk("nobp_idle_busy", 32'(busy), 32'(0));
        chk("nobp_idle_valid", 32'(m_valid), 32'(0));

        // Random 50% backpressure.
        step_cycle(1'b1, 1'b0);
        wait_done("randbp", 1, -1, 12000);
        check_frame("randbp", 1'b0);
        step_cycle(1'b0, 1'b1);

        // Long stall right after the first beat appears.
        step_cycle(1'b1, 1'b0);
        repeat (102) step_cycle(1'b0, 1'b0);
        chk("stall_valid", 32'(m_valid), 32'(1));
        chk("stall_head", 32'(m_data), 32'(0));
        chk("stall_ram_addr", 32'(ram_addr), 32'(1));
        chk("stall_busy", 32'(busy), 32'(1));
        wait_done("stall", 0, -1, 3000);
        check_frame("stall", 1'b0);
        step_cycle(1'b0, 1'b1);

        // Second start while busy is ignored.
        step_cycle(1'b1, 1'b1);
        wait_done("restart", 0, 500, 3000);
        check_frame("restart", 1'b1);
        step_cycle(1'b0, 1'b1);

        // Reset in the middle of a frame.
        step_cycle(1'b1, 1'b1);
        for (int i = 0; i < 3000 && beats < 1234; i++) step_cycle(1'b0, 1'b1);
        chk("midrst_reached", 32'(beats), 32'(1234));
        rst = 1'b1;
        step_cycle(1'b0, 1'b1);
        chk("midrst_valid", 32'(m_valid), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_ram_addr", 32'(ram_addr), 32'(0));
        chk("midrst_m_data", 32'(m_data), 32'(0));
        rst = 1'b0;
        step_cycle(1'b0, 1'b1);
        chk("midrst_idle_valid", 32'(m_valid), 32'(0));
        chk("midrst_idle_busy", 32'(busy), 32'(0));
        step_cycle(1'b1, 1'b1);
        wait_done("postrst", 0, -1, 3000);
        check_frame("postrst", 1'b1);

        // Back-to-back: start in the first idle cycle; start on the done cycle is ignored.
        step_cycle(1'b1, 1'b1);
        chk("b2b_gap_busy", 32'(busy), 32'(0));
        step_cycle(1'b0, 1'b1);
        chk("b2b_busy_again", 32'(busy), 32'(1));
        wait_done("b2b", 0, 2502, 3000);
        check_frame("b2b", 1'b1);
        for (int i = 0; i < 3; i++) begin
            step_cycle(1'b0, 1'b1);
            chk("start_on_done_busy", 32'(busy), 32'(0));
            chk("start_on_done_valid", 32'(m_valid), 32'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
